// File: rtl/intra_mode_selector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | intra_mode_selector: streaming per-mode SAD with MPM penalty and a       |
// | sequential lowest-cost mode search.                  Revision: 1.0       |
// +--------------------------------------------------------------------------+
module intra_mode_selector #(
  parameter int NUM_MODES      = 9,
  parameter int MODE_BITS      = 4,
  parameter int BLOCK_PIXELS   = 16,
  parameter int LANES          = 4,
  parameter int RES_WIDTH      = 9,
  parameter int SAD_WIDTH      = 16,
  parameter int MB_NUMBER_BITS = 12
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [NUM_MODES*LANES*RES_WIDTH-1:0]   in_res,
  input  logic [NUM_MODES-1:0]                   in_mode_mask,
  input  logic [MODE_BITS-1:0]                   in_pred_mode,
  input  logic [MB_NUMBER_BITS:0]                in_mbnumber,
  input  logic [SAD_WIDTH-1:0]                   cfg_penalty,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [MODE_BITS-1:0]                   out_mode,
  output logic [SAD_WIDTH-1:0]                   out_sad,
  output logic [MB_NUMBER_BITS:0]                out_mbnumber,
  output logic                                   out_none
);

  localparam int BEATS = BLOCK_PIXELS / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SUM_W = RES_WIDTH + $clog2(LANES) + 1;
  localparam int EXT_W = ((SUM_W > SAD_WIDTH) ? SUM_W : SAD_WIDTH) + 1;
  localparam logic [SAD_WIDTH-1:0] SAD_MAX   = '1;
  localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [MODE_BITS-1:0] LAST_MODE = MODE_BITS'(NUM_MODES - 1);

  typedef enum logic [1:0] {ST_ACCUM, ST_COMPARE, ST_OUTPUT} state_t;

  state_t                              state_q, state_d;
  logic [CNT_W-1:0]                    cnt_q;
  logic [SAD_WIDTH-1:0]                acc_q [NUM_MODES];
  logic [NUM_MODES-1:0][SAD_WIDTH-1:0] acc_next;
  logic [NUM_MODES-1:0]                mask_q;
  logic [MODE_BITS-1:0]                pred_q, idx_q, best_mode_q;
  logic [SAD_WIDTH-1:0]                pen_q, best_cost_q;
  logic [MB_NUMBER_BITS:0]             mb_q;
  logic                                found_q;
  logic                                out_valid_q, out_none_q;
  logic [MODE_BITS-1:0]                out_mode_q;
  logic [SAD_WIDTH-1:0]                out_sad_q;
  logic [MB_NUMBER_BITS:0]             out_mb_q;

  logic                 accept, first_beat, last_beat, better;
  logic [SAD_WIDTH-1:0] pen_eff, cost;
  logic [SAD_WIDTH:0]   cost_ext;

  // Two's-complement magnitude; the most negative code maps to 2^(RES_WIDTH-1) unsigned.
  function automatic logic [RES_WIDTH-1:0] abs_res(input logic [RES_WIDTH-1:0] r);
    return r[RES_WIDTH-1] ? (~r + RES_WIDTH'(1)) : r;
  endfunction

  assign accept     = in_valid && (state_q == ST_ACCUM);
  assign first_beat = (cnt_q == '0);
  assign last_beat  = (cnt_q == LAST_BEAT);

  for (genvar g = 0; g < NUM_MODES; g++) begin : g_mode
    logic [SUM_W-1:0] beat_sum;
    logic [EXT_W-1:0] sum_ext;
    always_comb begin
      beat_sum = '0;
      for (int l = 0; l < LANES; l++)
        beat_sum = beat_sum + SUM_W'(abs_res(in_res[(g*LANES+l)*RES_WIDTH +: RES_WIDTH]));
      sum_ext = EXT_W'(beat_sum) + (first_beat ? '0 : EXT_W'(acc_q[g]));
    end
    assign acc_next[g] = (sum_ext > EXT_W'(SAD_MAX)) ? SAD_MAX : sum_ext[SAD_WIDTH-1:0];
  end

  always_comb begin
    pen_eff  = (idx_q == pred_q) ? '0 : pen_q;
    cost_ext = {1'b0, acc_q[idx_q]} + {1'b0, pen_eff};
    cost     = cost_ext[SAD_WIDTH] ? SAD_MAX : cost_ext[SAD_WIDTH-1:0];
    better   = mask_q[idx_q] && (!found_q || (cost < best_cost_q));
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (accept && last_beat) state_d = ST_COMPARE;
      end
      ST_COMPARE: if (idx_q == LAST_MODE) state_d = ST_OUTPUT;
      ST_OUTPUT:  if (out_valid_q && out_ready) state_d = ST_ACCUM;
      default:    state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_ACCUM;
      cnt_q       <= '0;
      for (int m = 0; m < NUM_MODES; m++) acc_q[m] <= '0;
      mask_q      <= '0;
      pred_q      <= '0;
      pen_q       <= '0;
      mb_q        <= '0;
      idx_q       <= '0;
      found_q     <= 1'b0;
      best_cost_q <= '0;
      best_mode_q <= '0;
      out_valid_q <= 1'b0;
      out_none_q  <= 1'b0;
      out_mode_q  <= '0;
      out_sad_q   <= '0;
      out_mb_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_ACCUM: if (accept) begin
          for (int m = 0; m < NUM_MODES; m++) acc_q[m] <= acc_next[m];
          if (first_beat) begin
            mask_q <= in_mode_mask;
            pred_q <= in_pred_mode;
            pen_q  <= cfg_penalty;
            mb_q   <= in_mbnumber;
          end
          if (last_beat) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            found_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_COMPARE: begin
          if (better) begin
            found_q     <= 1'b1;
            best_cost_q <= cost;
            best_mode_q <= idx_q;
          end
          idx_q <= idx_q + MODE_BITS'(1);
        end
        ST_OUTPUT: begin
          // First OUTPUT cycle publishes the result; afterwards hold until accepted.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_none_q  <= !found_q;
            out_mode_q  <= found_q ? best_mode_q : '0;
            out_sad_q   <= found_q ? best_cost_q : SAD_MAX;
            out_mb_q    <= mb_q;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign out_none     = out_none_q;
  assign out_mode     = out_mode_q;
  assign out_sad      = out_sad_q;
  assign out_mbnumber = out_mb_q;

endmodule
`default_nettype wire

// File: tb/tb_intra_mode_selector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_intra_mode_selector: directed vectors on three selector configs.      |
// |                                                      Revision: 1.0       |
// +--------------------------------------------------------------------------+
module tb_intra_mode_selector;
  localparam int NM = 9;
  localparam int LN = 4;
  localparam int RW = 9;

  typedef struct packed {
    logic [1:0]  dut;
    logic [8:0]  mask;
    logic [3:0]  pred;
    logic [15:0] pen;
    logic [2:0]  nl;
    logic [80:0] v;
    logic [3:0]  emode;
    logic [15:0] esad;
    logic        enone;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]           inv = '0;
  logic [2:0]           ordy = '0;
  logic [NM*LN*RW-1:0]  res = '0;
  logic [8:0]           mask = '0;
  logic [3:0]           pred = '0;
  logic [12:0]          mb = '0;
  logic [15:0]          pen = '0;
  logic [2:0]           ov, ir, on;
  logic [3:0]           om [3];
  logic [15:0]          os [3];
  logic [12:0]          omb [3];
  logic [7:0]           sad8;
  assign os[2] = {8'h00, sad8};

  int checks = 0;
  int failures = 0;
  vec_t vecs [10];

  intra_mode_selector u0 (
    .clk(clk), .reset(reset), .in_valid(inv[0]), .in_ready(ir[0]), .in_res(res),
    .in_mode_mask(mask), .in_pred_mode(pred), .in_mbnumber(mb), .cfg_penalty(pen),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_mode(om[0]), .out_sad(os[0]),
    .out_mbnumber(omb[0]), .out_none(on[0]));

  intra_mode_selector #(.BLOCK_PIXELS(4)) u1 (
    .clk(clk), .reset(reset), .in_valid(inv[1]), .in_ready(ir[1]), .in_res(res),
    .in_mode_mask(mask), .in_pred_mode(pred), .in_mbnumber(mb), .cfg_penalty(pen),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_mode(om[1]), .out_sad(os[1]),
    .out_mbnumber(omb[1]), .out_none(on[1]));

  intra_mode_selector #(.SAD_WIDTH(8)) u2 (
    .clk(clk), .reset(reset), .in_valid(inv[2]), .in_ready(ir[2]), .in_res(res),
    .in_mode_mask(mask), .in_pred_mode(pred), .in_mbnumber(mb), .cfg_penalty(pen[7:0]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_mode(om[2]), .out_sad(sad8),
    .out_mbnumber(omb[2]), .out_none(on[2]));

  function automatic logic [80:0] p9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    logic [80:0] r;
    r[0*RW +: RW] = a0[8:0]; r[1*RW +: RW] = a1[8:0]; r[2*RW +: RW] = a2[8:0];
    r[3*RW +: RW] = a3[8:0]; r[4*RW +: RW] = a4[8:0]; r[5*RW +: RW] = a5[8:0];
    r[6*RW +: RW] = a6[8:0]; r[7*RW +: RW] = a7[8:0]; r[8*RW +: RW] = a8[8:0];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive_beat(input vec_t v, input logic [12:0] tag);
    res = '0;
    for (int m = 0; m < NM; m++)
      for (int l = 0; l < LN; l++)
        if (l < int'(v.nl)) res[(m*LN+l)*RW +: RW] = v.v[m*RW +: RW];
    mask = v.mask;
    pred = v.pred;
    pen  = v.pen;
    mb   = tag;
  endtask

  task automatic send_block(input vec_t v, input logic [12:0] tag, input int gap);
    int nb;
    nb = (v.dut == 2'd1) ? 1 : 4;
    for (int b = 0; b < nb; b++) begin
      drive_beat(v, tag);
      inv[v.dut] = 1'b1;
      @(posedge clk); #1;
      inv[v.dut] = 1'b0;
      if (b != nb - 1) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_out(input int d, output int lat);
    lat = 0;
    while (!ov[d] && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic check_out(input string t, input int d, input vec_t v, input logic [12:0] tag);
    chk({t, "_mode"}, om[d], v.emode);
    chk({t, "_sad"}, os[d], v.esad);
    chk({t, "_none"}, on[d], v.enone);
    chk({t, "_tag"}, omb[d], tag);
  endtask

  task automatic handshake(input string t, input int d);
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
    chk({t, "_valid_drop"}, ov[d], 1'b0);
    chk({t, "_in_ready_back"}, ir[d], 1'b1);
  endtask

  task automatic run_vec(input string t, input vec_t v, input logic [12:0] tag, input int gap);
    int lat;
    send_block(v, tag, gap);
    wait_out(int'(v.dut), lat);
    chk({t, "_latency"}, lat, NM + 1);
    check_out(t, int'(v.dut), v, tag);
    handshake(t, int'(v.dut));
  endtask

  initial begin
    int lat;
    vec_t dv;
    vecs[0] = '{2'd1, 9'h1FF, 4'd0,  16'd0,   3'd4, p9(9,8,7,6,5,4,3,2,1),               4'd8, 16'd4,    1'b0};
    vecs[1] = '{2'd0, 9'h1FF, 4'd5,  16'd3,   3'd1, p9(10,10,5,10,10,5,10,10,10),        4'd5, 16'd20,   1'b0};
    vecs[2] = '{2'd0, 9'h1FF, 4'd5,  16'd0,   3'd1, p9(10,10,5,10,10,5,10,10,10),        4'd2, 16'd20,   1'b0};
    vecs[3] = '{2'd2, 9'h1FF, 4'd0,  16'd0,   3'd4, p9(-256,-256,-256,-256,-256,-256,-256,-256,-256), 4'd0, 16'd255, 1'b0};
    vecs[4] = '{2'd2, 9'h1FF, 4'd15, 16'd100, 3'd2, p9(25,25,25,25,20,25,25,25,25),      4'd0, 16'd255,  1'b0};
    vecs[5] = '{2'd0, 9'h010, 4'd0,  16'd0,   3'd4, p9(1,1,1,1,30,1,1,1,1),              4'd4, 16'd480,  1'b0};
    vecs[6] = '{2'd0, 9'h000, 4'd0,  16'd0,   3'd4, p9(1,1,1,1,30,1,1,1,1),              4'd0, 16'hFFFF, 1'b1};
    vecs[7] = '{2'd0, 9'h1FF, 4'd12, 16'd7,   3'd1, p9(9,8,3,4,7,3,6,5,9),               4'd2, 16'd19,   1'b0};
    vecs[8] = '{2'd0, 9'h1FF, 4'd1,  16'd50,  3'd3, p9(-5,-6,4,-7,8,9,-9,5,6),           4'd1, 16'd72,   1'b0};
    vecs[9] = '{2'd1, 9'h1FF, 4'd6,  16'd1,   3'd4, p9(2,2,2,2,2,2,2,2,2),               4'd6, 16'd8,    1'b0};

    #23 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_out_valid", ov[0], 1'b0);
    chk("rst_in_ready", ir[0], 1'b1);
    chk("rst_out_mode", om[0], 4'd0);
    chk("rst_out_sad", os[0], 16'd0);
    chk("rst_out_tag", omb[0], 13'd0);
    chk("rst_out_none", on[0], 1'b0);

    for (int i = 0; i < 10; i++)
      run_vec($sformatf("vec%0d", i), vecs[i], 13'(100 + 37 * i), 0);

    // Bubbled input, stalled output, and an attempted beat while the result is held.
    send_block(vecs[8], 13'h1ABC, 2);
    wait_out(0, lat);
    chk("bp_latency", lat, NM + 1);
    dv = vecs[8];
    dv.v = p9(100,100,100,100,100,100,100,100,100);
    for (int k = 0; k < 5; k++) begin
      drive_beat(dv, 13'h0F0F);
      inv[0] = 1'b1;
      check_out($sformatf("bp_stall%0d", k), 0, vecs[8], 13'h1ABC);
      chk($sformatf("bp_stall%0d_valid", k), ov[0], 1'b1);
      chk($sformatf("bp_stall%0d_in_ready", k), ir[0], 1'b0);
      @(posedge clk); #1;
    end
    inv[0] = 1'b0;
    handshake("bp", 0);
    run_vec("bp_next", vecs[2], 13'h0222, 0);

    // Reset while a result is being presented.
    send_block(vecs[9], 13'h0055, 0);
    wait_out(1, lat);
    chk("rst_out_pre_valid", ov[1], 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rst_out_valid_async", ov[1], 1'b0);
    chk("rst_out_in_ready", ir[1], 1'b1);
    #3 reset = 1'b0;
    @(posedge clk); #1;

    // Reset after two of four beats; the discarded beats load mode 2 heavily.
    dv = vecs[2];
    dv.v = p9(0,0,100,0,0,0,0,0,0);
    dv.nl = 3'd4;
    for (int b = 0; b < 2; b++) begin
      drive_beat(dv, 13'h0777);
      inv[0] = 1'b1;
      @(posedge clk); #1;
    end
    inv[0] = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_valid", ov[0], 1'b0);
    chk("rst_mid_in_ready", ir[0], 1'b1);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    run_vec("rst_mid_next", vecs[2], 13'h0333, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
